// File: rtl/ring_fifo_if.sv
// Purpose: handshake and status bundle between a ring_fifo and the logic that uses it.
// Latency: none, wires only; the FIFO's one-cycle read latency appears on dataout/val.
// Backpressure: the producer watches full/almost_full and the consumer watches empty/almost_empty.
//
// Ports (master = FIFO user, slave = FIFO):
//   write, datain    : write request and write data           (master -> slave)
//   read             : read request                            (master -> slave)
//   err_clr          : synchronous clear of sticky error flags (master -> slave)
//   dataout, val     : registered read data and its valid pulse (slave -> master)
//   full, empty, almost_full, almost_empty, count : occupancy status (slave -> master)
//   overflow, underflow : sticky dropped-access flags          (slave -> master)
interface ring_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              write;
  logic [DATA_W-1:0] datain;
  logic              read;
  logic              err_clr;
  logic [DATA_W-1:0] dataout;
  logic              val;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output write, datain, read, err_clr,
    input  dataout, val, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  write, datain, read, err_clr,
    output dataout, val, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/ring_fifo.sv
// Purpose: circular-buffer FIFO of any DEPTH >= 2 with occupancy count and threshold flags.
// Latency: one cycle from the edge that accepts a read to dataout/val; flags follow count.
// Backpressure: writes to a full FIFO are dropped unless a read is accepted in the same cycle.
//
// Ports: clk (rising edge), reset (asynchronous, active-high), bus (ring_fifo_if.slave).
// Optional macro RING_FIFO_ERR_EN: when defined, overflow/underflow are sticky flags
// cleared by err_clr; when undefined they are tied low and err_clr is ignored.
module ring_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int AF_TH  = 3,
  parameter int AE_TH  = 1
) (
  input logic       clk,
  input logic       reset,
  ring_fifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_TH);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] dataout_q;
  logic              val_q;

  logic full_w;
  logic empty_w;
  logic rd_ok;
  logic wr_ok;

  // Explicit wrap compare so non-power-of-two depths never index past the array.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign full_w  = (count_q == CNT_FULL);
  assign empty_w = (count_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write
  // alongside it. An empty FIFO cannot bypass the incoming word to the read side.
  assign rd_ok = bus.read && !empty_w;
  assign wr_ok = bus.write && (!full_w || rd_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp] <= bus.datain;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp        <= '0;
      rp        <= '0;
      count_q   <= '0;
      dataout_q <= '0;
      val_q     <= 1'b0;
    end else begin
      if (wr_ok) begin
        wp <= ptr_next(wp);
      end
      if (rd_ok) begin
        dataout_q <= mem[rp];
        rp        <= ptr_next(rp);
      end
      val_q <= rd_ok;
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.dataout      = dataout_q;
  assign bus.val          = val_q;
  assign bus.count        = count_q;
  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (count_q >= CNT_AF);
  assign bus.almost_empty = (count_q <= CNT_AE);

`ifdef RING_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.write && full_w && !bus.read) begin
        overflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        overflow_q <= 1'b0;
      end
      if (bus.read && empty_w) begin
        underflow_q <= 1'b1;
      end else if (bus.err_clr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_ring_fifo.sv
// Purpose: self-checking bench for ring_fifo at DEPTH=5 against a queue-based model.
// Latency: expects dataout/val one cycle after an accepted read, flags with count.
// Backpressure: model drops writes when full (unless read together) and reads when empty.
module tb_ring_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF_TH = 4;
  localparam int AE_TH = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic reset;

  ring_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  ring_fifo #(
    .DATA_W(DW),
    .DEPTH (DEPTH),
    .AF_TH (AF_TH),
    .AE_TH (AE_TH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus the last read word and error flags.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_val;
  logic          m_ovf;
  logic          m_udf;

  task automatic model_clear();
    mq.delete();
    m_dout = '0;
    m_val  = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, return 1 ns after it.
  task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    bit rd;
    bit wr;
    int n;
    @(negedge clk);
    bus.write   = w;
    bus.datain  = d;
    bus.read    = r;
    bus.err_clr = c;
    @(posedge clk);
    n  = mq.size();
    rd = r && (n > 0);
    wr = w && ((n < DEPTH) || rd);
`ifdef RING_FIFO_ERR_EN
    if (w && n == DEPTH && !r) m_ovf = 1'b1;
    else if (c)                m_ovf = 1'b0;
    if (r && n == 0)           m_udf = 1'b1;
    else if (c)                m_udf = 1'b0;
`endif
    if (rd) begin
      m_dout = mq.pop_front();
      m_val  = 1'b1;
    end else begin
      m_val = 1'b0;
    end
    if (wr) mq.push_back(d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.err_clr = 1'b0;
    bus.datain  = '0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] act;
    do_reset();
    cycle(1'b0, '0, 1'b0, 1'b0);
    // {count, empty, full, almost_empty, almost_full, val, overflow, underflow}
    act = {bus.count, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
           bus.val, bus.overflow, bus.underflow};
    total++;
    if (act !== {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_flags: got %b want %b", act,
               {CW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    total++;
    if (bus.dataout !== '0) begin
      bad++;
      $display("FAIL reset_dataout: got %h want 00", bus.dataout);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'(8'h11 * (i + 1)), 1'b0, 1'b0);
      total++;
      if (bus.count !== CW'(i + 1)) begin
        bad++;
        $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1);
      end
    end
    total++;
    if (bus.full !== 1'b1 || bus.almost_full !== 1'b1) begin
      bad++;
      $display("FAIL fill_full: got full=%b af=%b want 1 1", bus.full, bus.almost_full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      total++;
      if (bus.val !== 1'b1 || bus.dataout !== DW'(8'h11 * (i + 1))
          || bus.count !== CW'(DEPTH - 1 - i)) begin
        bad++;
        $display("FAIL drain[%0d]: got val=%b data=%h count=%0d want 1 %h %0d", i,
                 bus.val, bus.dataout, bus.count, DW'(8'h11 * (i + 1)), DEPTH - 1 - i);
      end
    end
    total++;
    if (bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: got %b want 1", bus.empty);
    end
  endtask

  task automatic test_wrap();
    // Twelve writes and twelve reads move each pointer round a 5-entry ring twice.
    for (int i = 0; i < 14; i++) begin
      cycle(i < 12, DW'(8'h30 + i), i >= 2, 1'b0);
      total++;
      if (bus.val !== m_val || bus.dataout !== m_dout || bus.count !== CW'(mq.size())) begin
        bad++;
        $display("FAIL wrap[%0d]: got val=%b data=%h count=%0d want %b %h %0d", i,
                 bus.val, bus.dataout, bus.count, m_val, m_dout, mq.size());
      end
    end
    total++;
    if (m_dout !== 8'h3B || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_last: got model=%h empty=%b want 3b 1", m_dout, bus.empty);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'hB1 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hA0, 1'b1, 1'b0);
    total++;
    if (bus.val !== 1'b1 || bus.dataout !== 8'hB1 || bus.count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL full_rw: got val=%b data=%h count=%0d want 1 b1 %0d",
               bus.val, bus.dataout, bus.count, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.val !== 1'b1 || bus.dataout !== 8'hA0 || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL full_rw_last: got val=%b data=%h empty=%b want 1 a0 1",
               bus.val, bus.dataout, bus.empty);
    end
  endtask

  task automatic test_empty_rw();
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    total++;
    if (bus.val !== 1'b0 || bus.count !== CW'(1)) begin
      bad++;
      $display("FAIL empty_rw: got val=%b count=%0d want 0 1", bus.val, bus.count);
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.val !== 1'b1 || bus.dataout !== 8'h77) begin
      bad++;
      $display("FAIL empty_rw_read: got val=%b data=%h want 1 77", bus.val, bus.dataout);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.overflow !== m_ovf || bus.count !== CW'(DEPTH)) begin
      bad++;
      $display("FAIL overflow: got ovf=%b count=%0d want %b %0d",
               bus.overflow, bus.count, m_ovf, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.dataout !== 8'hC4) begin
      bad++;
      $display("FAIL overflow_drop: got %h want c4", bus.dataout);
    end
    // Read while empty together with err_clr: the new underflow must win.
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    total++;
    if (bus.overflow !== 1'b0 || bus.underflow !== m_udf || bus.count !== CW'(0)
        || bus.val !== 1'b0) begin
      bad++;
      $display("FAIL underflow: got ovf=%b udf=%b count=%0d val=%b want 0 %b 0 0",
               bus.overflow, bus.underflow, bus.count, bus.val, m_udf);
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    total++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got ovf=%b udf=%b want 0 0", bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_reset_midburst();
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'h61 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    bus.write  = 1'b1;
    bus.datain = 8'h99;
    bus.read   = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_clear();
    total++;
    if (bus.count !== '0 || bus.val !== 1'b0 || bus.dataout !== '0 || bus.empty !== 1'b1
        || bus.almost_empty !== 1'b1 || bus.full !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got count=%0d val=%b data=%h empty=%b ae=%b full=%b want 0 0 00 1 1 0",
               bus.count, bus.val, bus.dataout, bus.empty, bus.almost_empty, bus.full);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.val !== 1'b0 || bus.count !== '0) begin
      bad++;
      $display("FAIL reset_inflight: got val=%b count=%0d want 0 0", bus.val, bus.count);
    end
    @(negedge clk);
    bus.write = 1'b0;
    bus.read  = 1'b0;
    reset     = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    total++;
    if (bus.val !== 1'b1 || bus.dataout !== 8'h5A || bus.empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_restart: got val=%b data=%h empty=%b want 1 5a 1",
               bus.val, bus.dataout, bus.empty);
    end
  endtask

  task automatic test_random();
    logic [3:0] exp_flags;
    logic [3:0] act_flags;
    int n;
    for (int i = 0; i < 400; i++) begin
      // Alternate write-heavy and read-heavy phases to reach both full and empty.
      int wp_pct = ((i / 40) % 2 == 0) ? 75 : 25;
      cycle($urandom_range(99) < wp_pct, DW'($urandom), $urandom_range(99) >= wp_pct,
            $urandom_range(15) == 0);
      n = mq.size();
      exp_flags = {n == DEPTH, n == 0, n >= AF_TH, n <= AE_TH};
      act_flags = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};
      total++;
      if (bus.val !== m_val || bus.dataout !== m_dout || bus.count !== CW'(n)
          || act_flags !== exp_flags || bus.overflow !== m_ovf || bus.underflow !== m_udf) begin
        bad++;
        $display("FAIL random[%0d]: got val=%b data=%h count=%0d flags=%b ovf=%b udf=%b want %b %h %0d %b %b %b",
                 i, bus.val, bus.dataout, bus.count, act_flags, bus.overflow, bus.underflow,
                 m_val, m_dout, n, exp_flags, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    bus.write   = 1'b0;
    bus.read    = 1'b0;
    bus.err_clr = 1'b0;
    bus.datain  = '0;
    model_clear();
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_rw();
    test_empty_rw();
    test_errors();
    test_reset_midburst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
